sccb_cfg_sequencer: RTL

//  Upstream of the SCCB controller: walks an external register-init table and issues
//  one SCCB write per entry so the OV2640 is configured after power-up.

---
 rtl/sccb_cfg_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sccb_cfg_sequencer.sv
// Walks an external register-init table and issues one SCCB write per entry
// to configure an OV2640 after power-up (inline delays, END marker, NACK retry, timeout).
module sccb_cfg_sequencer #(
    parameter int         ADDR_W       = 8,
    parameter logic [7:0] DEV_ID       = 8'h60,
    parameter int         TICKS_PER_MS = 100000,
    parameter int         MAX_RETRY    = 3,
    parameter int         TIMEOUT_CYC  = 200000
) (
    input  logic              XCLK,
    input  logic              RST_N,
    input  logic              cfg_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [17:0]       rom_data,
    output logic              sccb_start,
    output logic [7:0]        sccb_addr_id,
    output logic [7:0]        sccb_addr_reg,
    output logic [7:0]        sccb_data,
    input  logic              sccb_busy,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_index
);
    localparam int DLY_NEED = $clog2(255 * TICKS_PER_MS + 1);
    localparam int DLY_W    = (DLY_NEED > 24) ? DLY_NEED : 24;
    localparam int TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int RTY_W    = 4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_OP   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_reg;
    logic [7:0]        r_data;
    logic [DLY_W-1:0]  r_dly;
    logic [TMO_W-1:0]  r_tmo;
    logic [RTY_W-1:0]  r_retry;
    logic              r_done;
    logic              r_error;
    logic [1:0]        r_code;
    logic [ADDR_W-1:0] r_eidx;

    logic [1:0]        w_op;
    logic              w_idle;
    logic              w_issue;
    logic              w_last;
    logic [RTY_W-1:0]  w_retry_nxt;
    logic [1:0]        w_err_code;
    logic [DLY_W-1:0]  w_dly_load;

    assign w_op        = rom_data[17:16];
    assign w_idle      = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    assign w_issue     = (r_state == S_ISSUE) && !sccb_busy;
    assign w_last      = &r_addr;
    assign w_retry_nxt = r_retry + RTY_W'(1);
    assign w_dly_load  = DLY_W'(rom_data[7:0]) * DLY_W'(TICKS_PER_MS);

    // NOTE: every output the comb block drives gets a default first, so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_err_code = ERR_OP;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (cfg_start) w_next = S_FETCH;
            S_FETCH:                 w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_WRITE: w_next = S_ISSUE;
                    OP_DELAY: w_next = (rom_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
                    OP_END:   w_next = S_DONE;
                    default:  w_next = S_ERROR;
                endcase
            end
            S_ISSUE: if (!sccb_busy) w_next = S_WAIT;
            S_WAIT: begin
                // A completion in the same cycle as the deadline still counts as a completion.
                if (sccb_done) begin
                    if (!sccb_nack)                             w_next = S_NEXT;
                    else if (w_retry_nxt <= RTY_W'(MAX_RETRY))  w_next = S_ISSUE;
                    else begin
                        w_next     = S_ERROR;
                        w_err_code = ERR_NACK;
                    end
                end else if (r_tmo == TMO_W'(TIMEOUT_CYC)) begin
                    w_next     = S_ERROR;
                    w_err_code = ERR_TMO;
                end
            end
            S_DELAY: if (r_dly == DLY_W'(1)) w_next = S_NEXT;
            S_NEXT:  w_next = w_last ? S_ERROR : S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset is sampled on the clock edge.
    always_ff @(posedge XCLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_reg   <= '0;
            r_data  <= '0;
            r_dly   <= '0;
            r_tmo   <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_code  <= '0;
            r_eidx  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (cfg_start) begin
                        r_addr  <= '0;
                        r_retry <= '0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_code  <= '0;
                        r_eidx  <= '0;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_WRITE) begin
                        r_reg  <= rom_data[15:8];
                        r_data <= rom_data[7:0];
                    end
                    if (w_op == OP_DELAY) r_dly <= w_dly_load;
                    if (w_op == OP_END)   r_done <= 1'b1;
                end
                // Counter holds the number of cycles elapsed since the start pulse.
                S_ISSUE: if (!sccb_busy) r_tmo <= TMO_W'(1);
                S_WAIT: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (sccb_done && sccb_nack) r_retry <= w_retry_nxt;
                end
                S_DELAY: r_dly <= r_dly - DLY_W'(1);
                S_NEXT: begin
                    r_retry <= '0;
                    if (!w_last) r_addr <= r_addr + ADDR_W'(1);
                end
                default: ;
            endcase
            if (w_next == S_ERROR && r_state != S_ERROR) begin
                r_error <= 1'b1;
                r_code  <= w_err_code;
                r_eidx  <= r_addr;
            end
        end
    end

    assign rom_addr      = r_addr;
    assign sccb_start    = w_issue;
    assign sccb_addr_id  = DEV_ID;
    assign sccb_addr_reg = r_reg;
    assign sccb_data     = r_data;
    assign cfg_busy      = !w_idle;
    assign cfg_done      = r_done;
    assign cfg_error     = r_error;
    assign err_code      = r_code;
    assign err_index     = r_eidx;
endmodule
